// File: rtl/ibex_pkg.sv
// Shared Ibex execute-path types: the FPU operator encoding and the issue sequencer state set.
package ibex_pkg;

  // FP_ALU_ADD is encoding zero so a cleared operator register selects ADD.
  typedef enum logic [2:0] {
    FP_ALU_ADD  = 3'd0,
    FP_ALU_SUB  = 3'd1,
    FP_ALU_MUL  = 3'd2,
    FP_ALU_DIV  = 3'd3,
    FP_ALU_MADD = 3'd4,
    FP_ALU_CVT  = 3'd5,
    FP_ALU_MIN  = 3'd6,
    FP_ALU_MAX  = 3'd7
  } fp_alu_op_e;

  typedef enum logic [2:0] {
    SEQ_IDLE = 3'd0,
    SEQ_EXEC = 3'd1,
    SEQ_MUL  = 3'd2,
    SEQ_ADD  = 3'd3,
    SEQ_DONE = 3'd4
  } fpu_seq_state_e;

  localparam logic [1:0] FPU_MODE_NONE = 2'b00;

  function automatic logic [15:0] madd_product(input logic [31:0] mul_res, input logic negate);
    return {mul_res[31] ^ negate, mul_res[30:16]};
  endfunction

endpackage

// File: rtl/fpu_madd_seq.sv
// Issue sequencer for the combinational bfloat16 FPU; adds MADD as a MUL-then-ADD/SUB pass.
// FPU_MADD_EN enables the two-pass MADD; without it MADD is reported illegal.
//
// state | meaning
// IDLE  | ready for a request, FPU driven from captured registers
// EXEC  | single-pass op in the FPU, result registered on exit
// MUL   | MADD pass 1: A*B, product rounded to bf16 and optionally negated
// ADD   | MADD pass 2: P +/- C, result registered on exit
// DONE  | response held until rsp_ready_i
module fpu_madd_seq
  import ibex_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  fp_alu_op_e       operator_i,
  input  logic [31:0]      operand_a_i,
  input  logic [15:0]      operand_b_i,
  input  logic [15:0]      operand_c_i,
  input  logic [1:0]       mode_i,
  output fp_alu_op_e       fpu_operator_o,
  output logic [31:0]      fpu_operand_a_o,
  output logic [15:0]      fpu_operand_b_o,
  output logic [1:0]       fpu_mode_o,
  input  logic [31:0]      fpu_result_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_result_o,
  output logic             rsp_illegal_o,
  output logic             busy_o
);

  fpu_seq_state_e state_q;
  fp_alu_op_e     fpu_op_q;
  logic [31:0]    fpu_a_q;
  logic [15:0]    fpu_b_q;
  logic [1:0]     fpu_mode_q;
  logic [31:0]    result_q;
  logic           illegal_q;

`ifdef FPU_MADD_EN
  // The FPU-facing registers get overwritten by the MADD passes, so the
  // request is also kept here to restore them once the sequence finishes.
  fp_alu_op_e     op_q;
  logic [31:0]    a_q;
  logic [15:0]    b_q;
  logic [15:0]    c_q;
  logic [1:0]     mode_q;
`else
  logic           unused_operand_c;
  assign unused_operand_c = ^operand_c_i;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SEQ_IDLE;
      fpu_op_q   <= FP_ALU_ADD;
      fpu_a_q    <= '0;
      fpu_b_q    <= '0;
      fpu_mode_q <= '0;
      result_q   <= '0;
      illegal_q  <= 1'b0;
`ifdef FPU_MADD_EN
      op_q       <= FP_ALU_ADD;
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      mode_q     <= '0;
`endif
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (req_valid_i) begin
            fpu_op_q   <= operator_i;
            fpu_a_q    <= operand_a_i;
            fpu_b_q    <= operand_b_i;
            fpu_mode_q <= mode_i;
            illegal_q  <= 1'b0;
`ifdef FPU_MADD_EN
            op_q       <= operator_i;
            a_q        <= operand_a_i;
            b_q        <= operand_b_i;
            c_q        <= operand_c_i;
            mode_q     <= mode_i;
`endif
            if (operator_i == FP_ALU_MADD) begin
`ifdef FPU_MADD_EN
              fpu_op_q   <= FP_ALU_MUL;
              fpu_mode_q <= FPU_MODE_NONE;
              state_q    <= SEQ_MUL;
`else
              result_q   <= '0;
              illegal_q  <= 1'b1;
              state_q    <= SEQ_DONE;
`endif
            end else begin
              state_q <= SEQ_EXEC;
            end
          end
        end
        SEQ_EXEC: begin
          result_q <= fpu_result_i;
          state_q  <= SEQ_DONE;
        end
`ifdef FPU_MADD_EN
        SEQ_MUL: begin
          fpu_op_q   <= mode_q[0] ? FP_ALU_SUB : FP_ALU_ADD;
          fpu_a_q    <= {madd_product(fpu_result_i, mode_q[1]), 16'h0000};
          fpu_b_q    <= c_q;
          fpu_mode_q <= FPU_MODE_NONE;
          state_q    <= SEQ_ADD;
        end
        SEQ_ADD: begin
          result_q   <= fpu_result_i;
          fpu_op_q   <= op_q;
          fpu_a_q    <= a_q;
          fpu_b_q    <= b_q;
          fpu_mode_q <= mode_q;
          state_q    <= SEQ_DONE;
        end
`endif
        SEQ_DONE: begin
          if (rsp_ready_i) begin
            state_q <= SEQ_IDLE;
          end
        end
        default: state_q <= SEQ_IDLE;
      endcase
    end
  end

  assign req_ready_o     = (state_q == SEQ_IDLE);
  assign rsp_valid_o     = (state_q == SEQ_DONE);
  assign busy_o          = (state_q != SEQ_IDLE);
  assign rsp_result_o    = result_q;
  assign rsp_illegal_o   = illegal_q;
  assign fpu_operator_o  = fpu_op_q;
  assign fpu_operand_a_o = fpu_a_q;
  assign fpu_operand_b_o = fpu_b_q;
  assign fpu_mode_o      = fpu_mode_q;

endmodule

// File: doc/fpu_madd_seq.md
# fpu_madd_seq

Multi-cycle issue sequencer sitting directly upstream of the combinational bfloat16 FPU in the Ibex execute path. Accepts one FP request at a time over a valid/ready handshake, registers operands, drives the FPU's operator/operand/mode inputs, and returns a registered result over a second valid/ready handshake. Implements the fused multiply-add family (FP_ALU_MADD), which the FPU lacks, as a two-pass MUL-then-ADD/SUB sequence through the same FPU.

## Interface
- Parameters: none.
- clk_i  in  1  clock
- rst_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when high with req_valid_i
- operator_i  in  ibex_pkg::fp_alu_op_e  requested operation
- operand_a_i  in  32  operand A (bfloat16 in [31:16], or integer for CVT)
- operand_b_i  in  16  operand B (bfloat16)
- operand_c_i  in  16  addend C for MADD (bfloat16)
- mode_i  in  2  FPU mode bits; for MADD: [0]=subtract C, [1]=negate product
- fpu_operator_o  out  fp_alu_op_e  to FPU operator input
- fpu_operand_a_o  out  32  to FPU operand A
- fpu_operand_b_o  out  16  to FPU operand B
- fpu_mode_o  out  2  to FPU mode input
- fpu_result_i  in  32  FPU combinational result
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when high with rsp_valid_o
- rsp_result_o  out  32  registered result
- rsp_illegal_o  out  1  request was unsupported
- busy_o  out  1  high in any state other than IDLE

## Operation
- States: IDLE, EXEC, MUL, ADD, DONE.
- IDLE: req_ready_o=1. On req_valid_i: capture operator, A, B, C, mode; go to MUL if operator is FP_ALU_MADD, else EXEC.
- EXEC: drive FPU with captured op/A/B/mode; register fpu_result_i into result reg; go to DONE.
- MUL: drive FP_ALU_MUL, A, B; capture fpu_result_i[31:16] as product P; flip P[15] if mode[1]; go to ADD.
- ADD: drive FP_ALU_SUB if mode[0] else FP_ALU_ADD; operand A = {P, 16'h0000}; operand B = C; FPU mode = 2'b00; register result; go to DONE.
- DONE: rsp_valid_o=1; result and illegal stable until rsp_ready_i; on rsp_ready_i go to IDLE.
- req_ready_o is high only in IDLE; no accept in DONE even if rsp_ready_i is high.
- FPU outputs always driven from captured registers in IDLE/DONE/EXEC; stage-specific values only in MUL/ADD.
- Product intermediate rounded to bfloat16 by the FPU (not a true fused op); this is the defined behaviour.

## Timing
- Reset (async assert, sync release): state=IDLE, req_ready_o=1 after release, rsp_valid_o=0, rsp_result_o=0, rsp_illegal_o=0, busy_o=0, all captured regs 0, fpu_operator_o=FP_ALU_ADD.
- Non-MADD: accept cycle N, EXEC N+1, rsp_valid_o high from N+2.
- MADD: accept N, MUL N+1, ADD N+2, rsp_valid_o high from N+3.
- Max throughput: one op per 3 cycles (non-MADD), 4 cycles (MADD), with rsp_ready_i held high.
- Reset mid-operation: in-flight request discarded, no response emitted.
- Backpressure: rsp_ready_i low holds DONE indefinitely, outputs unchanged.

## Configuration
- FPU_MADD_EN defined: MADD sequenced as above.
- Undefined: MUL/ADD states removed; MADD accepted and goes directly IDLE->DONE (rsp_valid_o at N+1) with rsp_result_o=0, rsp_illegal_o=1. All other ops unaffected; rsp_illegal_o always 0 for them.

## Structure
- ibex_pkg: add fpu_seq_state_e (IDLE, EXEC, MUL, ADD, DONE); reuse existing fp_alu_op_e.
- No sub-module: the FPU is instantiated beside this block in the parent and wired through fpu_* ports.

## Test plan
- ADD: A=0x3F800000 (1.0), B=0x4000 (2.0) -> rsp_result_o=0x40400000 at N+2, illegal=0.
- MADD mode 00: A=0x40000000, B=0x4040, C=0x3F80 -> 0x40E00000 (7.0) at N+3; fpu_operator_o=MUL at N+1, ADD at N+2.
- MADD mode 01 -> 0x40A00000 (5.0); mode 10 -> 0xC0A00000 (-5.0).
- Backpressure: rsp_ready_i low 5 cycles in DONE -> rsp_valid_o, rsp_result_o stable, req_ready_o=0, new req_valid_i ignored.
- Reset asserted in ADD state -> rsp_valid_o=0 immediately, busy_o=0, no response after release; next ADD returns correct result.
- FPU_MADD_EN undefined: MADD request -> rsp_valid_o at N+1, result 0, rsp_illegal_o=1; following ADD gives illegal=0.
